// File: rtl/pcpi_fir_estimator_pkg.sv
// Shared decode constants, FSM state type and accumulator sizing for the PCPI FIR estimator.
package fir_estimator_pkg;

  localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;
  localparam logic [6:0] FUNCT7_FIR   = 7'b0000001;
  localparam logic [2:0] FUNCT3_CFG   = 3'b000;
  localparam logic [2:0] FUNCT3_WCOEF = 3'b001;
  localparam logic [2:0] FUNCT3_PUSH  = 3'b010;
  localparam logic [2:0] FUNCT3_RUN   = 3'b011;
  localparam logic [2:0] FUNCT3_STAT  = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    ACCUM,
    DONE,
    GUARD
  } state_t;

  // Worst case is every one of the K*N coefficients added with the same sign.
  function automatic int acc_width(input int w, input int k, input int n);
    return w + $clog2(k * n) + 1;
  endfunction

endpackage

// File: rtl/pcpi_fir_estimator_if.sv
// PCPI handshake bundle between the picorv32 core (master) and the FIR estimator (slave).
interface pcpi_fir_estimator_if;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

endinterface

// File: rtl/pcpi_fir_estimator_tap_lane.sv
// One accumulator lane: adds or subtracts each of a tap's N coefficients according to its control bit.
module fir_tap_lane
  import fir_estimator_pkg::*;
#(
  parameter int N                 = 8,
  parameter int K                 = 128,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int ACC_W             = acc_width(WIDTH_COEFFICIENT, K, N)
) (
  input  logic                                en,
  input  logic [N-1:0]                        bits,
  input  logic signed [WIDTH_COEFFICIENT-1:0] coefs [N],
  output logic signed [ACC_W-1:0]             partial
);

  logic signed [ACC_W-1:0] ext;

  always_comb begin
    partial = '0;
    ext     = '0;
    for (int n = 0; n < N; n++) begin
      ext = {{(ACC_W-WIDTH_COEFFICIENT){coefs[n][WIDTH_COEFFICIENT-1]}}, coefs[n]};
      if (en) partial = bits[n] ? (partial + ext) : (partial - ext);
    end
  end

endmodule

// File: rtl/pcpi_fir_estimator.sv
// PCPI custom-0 FIR estimator: coefficient memory, control-vector history, downsampler, lane-parallel accumulator.
// Build option: define FIR_SATURATE_EN to clamp RUN results to the signed 32-bit range instead of wrapping.
module pcpi_fir_estimator
  import fir_estimator_pkg::*;
#(
  parameter int N                 = 8,
  parameter int K                 = 128,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int LANES             = 4,
  parameter int DS_WIDTH          = 8
) (
  input logic                 clk,
  input logic                 resetn,
  pcpi_fir_estimator_if.slave pcpi
);

  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int KA_W  = KW + 1;
  localparam int DEPTH = K * N;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ACC_W = acc_width(WIDTH_COEFFICIENT, K, N);
  localparam int EXT_W = ACC_W + 32;

  localparam logic [KA_W-1:0]     K_FULL    = KA_W'(K);
  localparam logic [KA_W-1:0]     KA_ONE    = KA_W'(1);
  localparam logic [KA_W-1:0]     LANE_STEP = KA_W'(LANES);
  localparam logic [DS_WIDTH-1:0] DS_ONE    = DS_WIDTH'(1);

  state_t                         state, state_next;
  logic [2:0]                     op_q;
  logic [31:0]                    rs1_q, rs2_q;
  logic [KA_W-1:0]                k_act, fill, base, k_req;
  logic [DS_WIDTH-1:0]            osr, ds_cnt;
  logic                           smp_rdy;
  logic [N-1:0]                   hist [K];
  logic signed [WIDTH_COEFFICIENT-1:0] coef [DEPTH];
  logic signed [ACC_W-1:0]        acc, part_q, lane_total;
  logic signed [ACC_W-1:0]        lane_part [LANES];
  logic signed [EXT_W-1:0]        acc_ext;
  logic [31:0]                    run_rd, stat_word;
  logic                           insn_match, accept;

  assign insn_match = (pcpi.pcpi_insn[6:0] == OPC_CUSTOM0) && (pcpi.pcpi_insn[31:25] == FUNCT7_FIR);
  assign accept     = (state == IDLE) && pcpi.pcpi_valid && insn_match;
  assign k_req      = rs1_q[KA_W-1:0];
  assign stat_word  = {smp_rdy, 15'b0, 16'(fill)};

  // Tap slot k pairs history slot k (0 = newest) with coefficients k*N .. k*N+N-1.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [KA_W-1:0] tap;
    logic [KW-1:0]   slot;
    logic signed [WIDTH_COEFFICIENT-1:0] tap_coefs [N];

    always_comb begin
      tap  = base + KA_W'(l);
      slot = tap[KW-1:0];
      for (int n = 0; n < N; n++) tap_coefs[n] = coef[AW'(int'(slot) * N + n)];
    end

    fir_tap_lane #(
      .N                (N),
      .K                (K),
      .WIDTH_COEFFICIENT(WIDTH_COEFFICIENT),
      .ACC_W            (ACC_W)
    ) u_lane (
      .en     (tap < k_act),
      .bits   (hist[slot]),
      .coefs  (tap_coefs),
      .partial(lane_part[l])
    );
  end

  always_comb begin
    lane_total = '0;
    for (int l = 0; l < LANES; l++) lane_total = lane_total + lane_part[l];
  end

  always_comb begin
    acc_ext = {{32{acc[ACC_W-1]}}, acc};
`ifdef FIR_SATURATE_EN
    if (acc_ext > $signed({{(EXT_W-31){1'b0}}, {31{1'b1}}}))
      run_rd = 32'h7FFF_FFFF;
    else if (acc_ext < $signed({{(EXT_W-31){1'b1}}, {31{1'b0}}}))
      run_rd = 32'h8000_0000;
    else
      run_rd = acc_ext[31:0];
`else
    run_rd = acc_ext[31:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next      = state;
    pcpi.pcpi_wait  = 1'b0;
    pcpi.pcpi_ready = 1'b0;
    pcpi.pcpi_wr    = 1'b0;
    pcpi.pcpi_rd    = '0;
    case (state)
      IDLE: begin
        if (accept)
          state_next = (pcpi.pcpi_insn[14:12] == FUNCT3_RUN && fill >= k_act) ? ACCUM : EXEC;
      end
      EXEC: begin
        pcpi.pcpi_wait = 1'b1;
        state_next     = DONE;
      end
      ACCUM: begin
        pcpi.pcpi_wait = 1'b1;
        if (base >= k_act) state_next = DONE;
      end
      DONE: begin
        pcpi.pcpi_wait  = 1'b1;
        pcpi.pcpi_ready = 1'b1;
        state_next      = GUARD;
        if (op_q == FUNCT3_RUN) begin
          pcpi.pcpi_wr = 1'b1;
          pcpi.pcpi_rd = run_rd;
        end else if (op_q == FUNCT3_STAT) begin
          pcpi.pcpi_wr = 1'b1;
          pcpi.pcpi_rd = stat_word;
        end
      end
      GUARD:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ACCUM is pipelined: each cycle registers one lane group and folds in the previous one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      k_act   <= K_FULL;
      osr     <= DS_ONE;
      fill    <= '0;
      ds_cnt  <= '0;
      smp_rdy <= 1'b0;
      base    <= '0;
      acc     <= '0;
      part_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= pcpi.pcpi_insn[14:12];
        rs1_q  <= pcpi.pcpi_rs1;
        rs2_q  <= pcpi.pcpi_rs2;
        base   <= '0;
        acc    <= '0;
        part_q <= '0;
      end
      if (state == EXEC) begin
        case (op_q)
          FUNCT3_CFG: begin
            k_act <= (k_req == '0 || k_req > K_FULL) ? K_FULL : k_req;
            osr   <= (rs2_q[DS_WIDTH-1:0] == '0) ? DS_ONE : rs2_q[DS_WIDTH-1:0];
          end
          FUNCT3_PUSH: begin
            if (fill < K_FULL) fill <= fill + KA_ONE;
            if (ds_cnt >= osr - DS_ONE) begin
              ds_cnt  <= '0;
              smp_rdy <= 1'b1;
            end else begin
              ds_cnt <= ds_cnt + DS_ONE;
            end
          end
          default: ;
        endcase
      end
      if (state == ACCUM) begin
        acc    <= acc + part_q;
        part_q <= lane_total;
        if (base < k_act) base <= base + LANE_STEP;
      end
      if (state == DONE && op_q == FUNCT3_RUN) smp_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < K; k++) hist[k] <= '0;
    end else if (state == EXEC && op_q == FUNCT3_PUSH) begin
      hist[0] <= rs2_q[N-1:0];
      for (int k = 1; k < K; k++) hist[k] <= hist[k-1];
    end
  end

  // Coefficients survive reset so firmware need not reload them after a soft reset.
  always_ff @(posedge clk) begin
    if (resetn && state == EXEC && op_q == FUNCT3_WCOEF && rs1_q < 32'(DEPTH))
      coef[rs1_q[AW-1:0]] <= rs2_q[WIDTH_COEFFICIENT-1:0];
  end

endmodule
